// File: rtl/vc_stream_merge4.sv
`default_nettype none
// ============================================================================
// Module      : vc_stream_merge4
// Description : Merges four val/rdy producer streams into one registered
//               output stream. Arbitration is round-robin. A multi-beat
//               message keeps its grant until its last beat. Each output beat
//               is tagged with the index of the input that supplied it.
//               Throughput is one beat per cycle and latency is one cycle.
//
// Ports       : clk                   rising-edge clock
//               reset_n               synchronous active-low reset
//               inN_msg   [p_nbits]   input payloads (N = 0..3)
//               inN_val               input valid
//               inN_last              final beat of a message
//               inN_rdy               input ready (at most one high per cycle)
//               out_msg   [p_nbits]   registered payload
//               out_last              registered last flag
//               out_src   [2]         registered source index
//               out_val               output valid
//               out_rdy               downstream ready
// Revision    : 1.0  initial release
// ============================================================================
module vc_stream_merge4 #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic [p_nbits-1:0] in0_msg,
    input  logic               in0_val,
    input  logic               in0_last,
    output logic               in0_rdy,

    input  logic [p_nbits-1:0] in1_msg,
    input  logic               in1_val,
    input  logic               in1_last,
    output logic               in1_rdy,

    input  logic [p_nbits-1:0] in2_msg,
    input  logic               in2_val,
    input  logic               in2_last,
    output logic               in2_rdy,

    input  logic [p_nbits-1:0] in3_msg,
    input  logic               in3_val,
    input  logic               in3_last,
    output logic               in3_rdy,

    output logic [p_nbits-1:0] out_msg,
    output logic               out_last,
    output logic [1:0]         out_src,
    output logic               out_val,
    input  logic               out_rdy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_ptr;
    logic               r_locked;
    logic [1:0]         r_lock_src;
    logic [p_nbits-1:0] r_out_msg;
    logic               r_out_last;
    logic [1:0]         r_out_src;
    logic               r_out_val;

    // ------------------------------------------------------------------
    // Combinational grant
    // ------------------------------------------------------------------
    logic [3:0]         w_val;
    logic [3:0]         w_last;
    logic               w_can_load;
    logic [1:0]         w_grant;
    logic               w_grant_ok;
    logic [1:0]         w_idx;
    logic [3:0]         w_rdy;
    logic               w_xfer;
    logic [p_nbits-1:0] w_msg;

    assign w_val      = {in3_val,  in2_val,  in1_val,  in0_val};
    assign w_last     = {in3_last, in2_last, in1_last, in0_last};

    // Output register may load when empty or being drained this cycle.
    assign w_can_load = !r_out_val || out_rdy;

    always_comb begin
        w_grant    = 2'd0;
        w_grant_ok = 1'b0;
        w_idx      = 2'd0;
        if (r_locked) begin
            // Owner keeps the grant even while idle so no other source
            // can interleave beats into its message.
            w_grant    = r_lock_src;
            w_grant_ok = 1'b1;
        end else begin
            // Scan from lowest priority to highest so the last hit, i.e.
            // the one closest to r_ptr, wins.
            for (int i = 3; i >= 0; i--) begin
                w_idx = r_ptr + 2'(i);
                if (w_val[w_idx]) begin
                    w_grant    = w_idx;
                    w_grant_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rdy = 4'b0000;
        if (w_can_load && w_grant_ok) begin
            w_rdy[w_grant] = 1'b1;
        end
    end

    assign in0_rdy = w_rdy[0];
    assign in1_rdy = w_rdy[1];
    assign in2_rdy = w_rdy[2];
    assign in3_rdy = w_rdy[3];

    assign w_xfer  = |(w_rdy & w_val);

    always_comb begin
        w_msg = in0_msg;
        case (w_grant)
            2'd0:    w_msg = in0_msg;
            2'd1:    w_msg = in1_msg;
            2'd2:    w_msg = in2_msg;
            default: w_msg = in3_msg;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr      <= 2'd0;
            r_locked   <= 1'b0;
            r_lock_src <= 2'd0;
            r_out_msg  <= '0;
            r_out_last <= 1'b0;
            r_out_src  <= 2'd0;
            r_out_val  <= 1'b0;
        end else if (w_xfer) begin
            r_out_msg  <= w_msg;
            r_out_last <= w_last[w_grant];
            r_out_src  <= w_grant;
            r_out_val  <= 1'b1;
            if (w_last[w_grant]) begin
                // Message complete: release and make this source lowest
                // priority for the next round.
                r_locked <= 1'b0;
                r_ptr    <= w_grant + 2'd1;
            end else begin
                r_locked   <= 1'b1;
                r_lock_src <= w_grant;
            end
        end else if (out_rdy) begin
            r_out_val <= 1'b0;
        end
    end

    assign out_msg  = r_out_msg;
    assign out_last = r_out_last;
    assign out_src  = r_out_src;
    assign out_val  = r_out_val;

endmodule
`default_nettype wire

// File: tb/tb_vc_stream_merge4.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_stream_merge4
// Description : Directed, table-driven bench for vc_stream_merge4. Each
//               record drives one cycle of inputs and lists the expected
//               ready vector for that cycle and the registered outputs after
//               the following rising edge. Payload of input N is
//               0x100*N + seq.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vc_stream_merge4;

    localparam int c_nbits = 32;

    logic               clk;
    logic               reset_n;
    logic [c_nbits-1:0] r_msg [4];
    logic [3:0]         r_val;
    logic [3:0]         r_last;
    logic               r_out_rdy;
    logic [3:0]         w_rdy;
    logic [c_nbits-1:0] w_out_msg;
    logic               w_out_last;
    logic [1:0]         w_out_src;
    logic               w_out_val;

    int n_checks;
    int n_errors;

    vc_stream_merge4 #(.p_nbits(c_nbits)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in0_msg  (r_msg[0]), .in0_val (r_val[0]), .in0_last (r_last[0]), .in0_rdy (w_rdy[0]),
        .in1_msg  (r_msg[1]), .in1_val (r_val[1]), .in1_last (r_last[1]), .in1_rdy (w_rdy[1]),
        .in2_msg  (r_msg[2]), .in2_val (r_val[2]), .in2_last (r_last[2]), .in2_rdy (w_rdy[2]),
        .in3_msg  (r_msg[3]), .in3_val (r_val[3]), .in3_last (r_last[3]), .in3_rdy (w_rdy[3]),
        .out_msg  (w_out_msg),
        .out_last (w_out_last),
        .out_src  (w_out_src),
        .out_val  (w_out_val),
        .out_rdy  (r_out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  val;
        logic [3:0]  last;
        logic        ordy;
        logic [7:0]  seq;
        logic [3:0]  erdy;
        logic        eval;
        logic [1:0]  esrc;
        logic        elast;
        logic [31:0] emsg;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] val, input logic [3:0] last,
                                input logic ordy, input logic [7:0] seq,
                                input logic [3:0] erdy, input logic eval,
                                input logic [1:0] esrc, input logic elast,
                                input logic [31:0] emsg);
        vec_t v;
        v.val = val; v.last = last; v.ordy = ordy; v.seq = seq;
        v.erdy = erdy; v.eval = eval; v.esrc = esrc; v.elast = elast; v.emsg = emsg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        r_val     = v.val;
        r_last    = v.last;
        r_out_rdy = v.ordy;
        for (int n = 0; n < 4; n++) begin
            r_msg[n] = 32'h100 * n + 32'(v.seq);
        end
    endtask

    // Drive one cycle, check combinational ready mid-cycle, then check the
    // registered outputs just after the next rising edge.
    task automatic run_vec(input int idx, input vec_t v);
        drive(v);
        #3;
        check($sformatf("v%0d rdy", idx), 32'(w_rdy), 32'(v.erdy));
        @(posedge clk);
        #1;
        check($sformatf("v%0d out_val", idx),  32'(w_out_val),  32'(v.eval));
        check($sformatf("v%0d out_src", idx),  32'(w_out_src),  32'(v.esrc));
        check($sformatf("v%0d out_last", idx), 32'(w_out_last), 32'(v.elast));
        check($sformatf("v%0d out_msg", idx),  w_out_msg,       v.emsg);
    endtask

    vec_t vecs [25];

    initial begin
        n_checks = 0;
        n_errors = 0;

        //                val      last     ordy  seq    erdy     eval  src   last  msg
        // Fair rotation, pointer starts at 0
        vecs[0]  = mk(4'b1111, 4'b1111, 1'b1, 8'h01, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h001);
        vecs[1]  = mk(4'b1111, 4'b1111, 1'b1, 8'h02, 4'b0010, 1'b1, 2'd1, 1'b1, 32'h102);
        vecs[2]  = mk(4'b1111, 4'b1111, 1'b1, 8'h03, 4'b0100, 1'b1, 2'd2, 1'b1, 32'h203);
        vecs[3]  = mk(4'b1111, 4'b1111, 1'b1, 8'h04, 4'b1000, 1'b1, 2'd3, 1'b1, 32'h304);
        vecs[4]  = mk(4'b1111, 4'b1111, 1'b1, 8'h05, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h005);
        // Three-beat message from in2 with a two-cycle gap
        vecs[5]  = mk(4'b0100, 4'b0000, 1'b1, 8'h06, 4'b0100, 1'b1, 2'd2, 1'b0, 32'h206);
        vecs[6]  = mk(4'b1111, 4'b0000, 1'b1, 8'h07, 4'b0100, 1'b1, 2'd2, 1'b0, 32'h207);
        vecs[7]  = mk(4'b1011, 4'b1111, 1'b1, 8'h08, 4'b0100, 1'b0, 2'd2, 1'b0, 32'h207);
        vecs[8]  = mk(4'b1011, 4'b1111, 1'b1, 8'h09, 4'b0100, 1'b0, 2'd2, 1'b0, 32'h207);
        vecs[9]  = mk(4'b1111, 4'b0100, 1'b1, 8'h0A, 4'b0100, 1'b1, 2'd2, 1'b1, 32'h20A);
        vecs[10] = mk(4'b1111, 4'b1111, 1'b1, 8'h0B, 4'b1000, 1'b1, 2'd3, 1'b1, 32'h30B);
        // Backpressure for five cycles, then immediate reload
        vecs[11] = mk(4'b1111, 4'b1111, 1'b0, 8'h0C, 4'b0000, 1'b1, 2'd3, 1'b1, 32'h30B);
        vecs[12] = mk(4'b1111, 4'b1111, 1'b0, 8'h0D, 4'b0000, 1'b1, 2'd3, 1'b1, 32'h30B);
        vecs[13] = mk(4'b1111, 4'b1111, 1'b0, 8'h0E, 4'b0000, 1'b1, 2'd3, 1'b1, 32'h30B);
        vecs[14] = mk(4'b1111, 4'b1111, 1'b0, 8'h0F, 4'b0000, 1'b1, 2'd3, 1'b1, 32'h30B);
        vecs[15] = mk(4'b1111, 4'b1111, 1'b0, 8'h10, 4'b0000, 1'b1, 2'd3, 1'b1, 32'h30B);
        vecs[16] = mk(4'b1111, 4'b1111, 1'b1, 8'h11, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h011);
        // Sparse: bring ptr to 2, then only in1 valid, then in1+in2
        vecs[17] = mk(4'b1111, 4'b1111, 1'b1, 8'h12, 4'b0010, 1'b1, 2'd1, 1'b1, 32'h112);
        vecs[18] = mk(4'b0010, 4'b1111, 1'b1, 8'h13, 4'b0010, 1'b1, 2'd1, 1'b1, 32'h113);
        vecs[19] = mk(4'b0110, 4'b1111, 1'b1, 8'h14, 4'b0100, 1'b1, 2'd2, 1'b1, 32'h214);
        // Idle, then load into an empty register while downstream stalls
        vecs[20] = mk(4'b0000, 4'b1111, 1'b1, 8'h15, 4'b0000, 1'b0, 2'd2, 1'b1, 32'h214);
        vecs[21] = mk(4'b0000, 4'b1111, 1'b0, 8'h16, 4'b0000, 1'b0, 2'd2, 1'b1, 32'h214);
        vecs[22] = mk(4'b0001, 4'b1111, 1'b0, 8'h17, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h017);
        vecs[23] = mk(4'b0000, 4'b1111, 1'b0, 8'h18, 4'b0000, 1'b1, 2'd0, 1'b1, 32'h017);
        // in3 opens a message (ptr=1) just before the reset pulse below
        vecs[24] = mk(4'b1000, 4'b0000, 1'b1, 8'h19, 4'b1000, 1'b1, 2'd3, 1'b0, 32'h319);

        // Reset held two cycles with every input valid
        reset_n = 1'b0;
        drive(mk(4'b1111, 4'b1111, 1'b1, 8'hEE, 4'b0, 1'b0, 2'd0, 1'b0, 32'h0));
        repeat (2) @(posedge clk);
        #1;
        check("reset out_val", 32'(w_out_val), 32'd0);
        check("reset out_msg", w_out_msg,      32'd0);
        check("reset out_src", 32'(w_out_src), 32'd0);
        check("reset out_last", 32'(w_out_last), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset mid-message: lock and buffered beat are discarded
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset out_val", 32'(w_out_val), 32'd0);
        check("midreset out_msg", w_out_msg,      32'd0);
        reset_n = 1'b1;
        run_vec(100, mk(4'b1001, 4'b1001, 1'b1, 8'h1A, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h01A));
        run_vec(101, mk(4'b1001, 4'b1001, 1'b1, 8'h1B, 4'b1000, 1'b1, 2'd3, 1'b1, 32'h31B));
        // ptr wrapped 3 -> 0
        run_vec(102, mk(4'b1001, 4'b1001, 1'b1, 8'h1C, 4'b0001, 1'b1, 2'd0, 1'b1, 32'h01C));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
